// File: rtl/aq_vfmau_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aq_vfmau_pkg
// Brief   : Shared types and constants for the VFMAU write-back path.
// Revision: 1.0 - initial release
// ============================================================================
package aq_vfmau_pkg;

    localparam int c_DATA_W   = 64;
    localparam int c_FFLAGS_W = 5;
    localparam int c_TAG_W    = 5;
    localparam int c_MAX_PUSH = 3;

    localparam int c_FFLAG_NV = 4;
    localparam int c_FFLAG_DZ = 3;
    localparam int c_FFLAG_OF = 2;
    localparam int c_FFLAG_UF = 1;
    localparam int c_FFLAG_NX = 0;

    typedef struct packed {
        logic [c_DATA_W-1:0]   data;
        logic [c_FFLAGS_W-1:0] fflags;
        logic [c_TAG_W-1:0]    vreg;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/aq_vfmau_wb_pushsel.sv
`default_nettype none
// ============================================================================
// Module  : aq_vfmau_wb_pushsel
// Brief   : Compacts up to three completion strobes into contiguous slots.
// Revision: 1.0 - initial release
// ============================================================================
module aq_vfmau_wb_pushsel
    import aq_vfmau_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic [c_MAX_PUSH-1:0]      i_vld,   // bit 0 is the oldest source
    input  logic [CNT_W-1:0]           i_free,
    output logic [c_MAX_PUSH-1:0]      o_we,
    output logic [c_MAX_PUSH-1:0][1:0] o_off,
    output logic [1:0]                 o_cnt,
    output logic                       o_drop
);

    logic [1:0] w_cnt;

    // Acceptance is a prefix of the valid sources, so offsets stay contiguous.
    always_comb begin
        w_cnt  = 2'd0;
        o_we   = '0;
        o_off  = '0;
        o_drop = 1'b0;
        for (int i = 0; i < c_MAX_PUSH; i++) begin
            if (i_vld[i]) begin
                if (CNT_W'(w_cnt) < i_free) begin
                    o_we[i]  = 1'b1;
                    o_off[i] = w_cnt;
                    w_cnt    = w_cnt + 2'd1;
                end else begin
                    o_drop = 1'b1;
                end
            end
        end
    end

    assign o_cnt = w_cnt;

endmodule
`default_nettype wire

// File: rtl/aq_vfmau_wb_buf.sv
`default_nettype none
// ============================================================================
// Module  : aq_vfmau_wb_buf
// Brief   : In-order write-back buffer between the VFMAU pipe and the VPU RF.
// Revision: 1.0 - initial release
// ============================================================================
module aq_vfmau_wb_buf
    import aq_vfmau_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 5,
    parameter int STALL_TH = 3
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             ex3_vld,
    input  logic             ex4_vld,
    input  logic             ex5_vld,
    input  logic [63:0]      ex3_result,
    input  logic [63:0]      ex4_result,
    input  logic [63:0]      ex5_result,
    input  logic [4:0]       ex3_fflags,
    input  logic [4:0]       ex4_fflags,
    input  logic [4:0]       ex5_fflags,
    input  logic [TAG_W-1:0] ex3_vreg,
    input  logic [TAG_W-1:0] ex4_vreg,
    input  logic [TAG_W-1:0] ex5_vreg,
    input  logic             rtu_vpu_flush,
    input  logic             vpu_wb_grant,
    input  logic             fflags_acc_clr,
    output logic             wb_vld,
    output logic [63:0]      wb_data,
    output logic [4:0]       wb_fflags,
    output logic [TAG_W-1:0] wb_vreg,
    output logic             wb_stall,
    output logic [4:0]       fflags_acc,
    output logic             wb_ovf_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef struct packed {
        logic [c_DATA_W-1:0]   data;
        logic [c_FFLAGS_W-1:0] fflags;
        logic [TAG_W-1:0]      vreg;
    } entry_t;

    entry_t                      r_mem [DEPTH];
    logic [c_PTR_W-1:0]          r_rptr;
    logic [c_PTR_W-1:0]          r_wptr;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [4:0]                  r_fflags_acc;
    logic                        r_ovf_err;

    entry_t                      w_src [c_MAX_PUSH];
    entry_t                      w_head;
    logic [c_MAX_PUSH-1:0]       w_src_vld;
    logic [c_MAX_PUSH-1:0]       w_we;
    logic [c_MAX_PUSH-1:0][1:0]  w_off;
    logic [1:0]                  w_push_cnt;
    logic                        w_drop;
    logic                        w_pop;
    logic [c_CNT_W-1:0]          w_free;
    logic [c_CNT_W-1:0]          w_cnt_nxt;

    // Source 0 is the oldest instruction (ex5).
    assign w_src_vld = {ex3_vld, ex4_vld, ex5_vld};

    always_comb begin
        w_src[0] = '{data: ex5_result, fflags: ex5_fflags, vreg: ex5_vreg};
        w_src[1] = '{data: ex4_result, fflags: ex4_fflags, vreg: ex4_vreg};
        w_src[2] = '{data: ex3_result, fflags: ex3_fflags, vreg: ex3_vreg};
    end

    // Free space is taken before this cycle's pop; a same-cycle pop cannot make room.
    assign w_free    = c_CNT_W'(DEPTH) - r_cnt;
    assign w_head    = r_mem[r_rptr];
    assign w_pop     = (r_cnt != '0) & vpu_wb_grant;
    assign w_cnt_nxt = r_cnt + c_CNT_W'(w_push_cnt) - c_CNT_W'(w_pop);

    aq_vfmau_wb_pushsel #(
        .CNT_W (c_CNT_W)
    ) u_pushsel (
        .i_vld  (w_src_vld),
        .i_free (w_free),
        .o_we   (w_we),
        .o_off  (w_off),
        .o_cnt  (w_push_cnt),
        .o_drop (w_drop)
    );

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_rptr       <= '0;
            r_wptr       <= '0;
            r_cnt        <= '0;
            r_fflags_acc <= '0;
            r_ovf_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (rtu_vpu_flush) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < c_MAX_PUSH; i++) begin
                if (w_we[i]) begin
                    r_mem[r_wptr + c_PTR_W'(w_off[i])] <= w_src[i];
                end
            end
            r_wptr       <= r_wptr + c_PTR_W'(w_push_cnt);
            r_cnt        <= w_cnt_nxt;
            r_fflags_acc <= (fflags_acc_clr ? 5'd0 : r_fflags_acc)
                          | (w_pop ? w_head.fflags : 5'd0);
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (w_drop) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign wb_vld     = (r_cnt != '0);
    assign wb_data    = w_head.data;
    assign wb_fflags  = w_head.fflags;
    assign wb_vreg    = w_head.vreg;
    assign wb_stall   = (w_free < c_CNT_W'(STALL_TH));
    assign fflags_acc = r_fflags_acc;
    assign wb_ovf_err = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_aq_vfmau_wb_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_aq_vfmau_wb_buf
// Brief   : Self-checking bench: directed table, corner sequences, random vs model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aq_vfmau_wb_buf;
    import aq_vfmau_pkg::*;

    localparam int c_DEPTH    = 4;
    localparam int c_TB_TAG_W = 5;
    localparam int c_STALL_TH = 3;

    logic        clk = 1'b0;
    logic        rst_n, flush, grant, clr;
    logic        ex3_vld, ex4_vld, ex5_vld;
    logic [63:0] ex3_result, ex4_result, ex5_result;
    logic [4:0]  ex3_fflags, ex4_fflags, ex5_fflags;
    logic [4:0]  ex3_vreg, ex4_vreg, ex5_vreg;
    logic        wb_vld, wb_stall, wb_ovf_err;
    logic [63:0] wb_data;
    logic [4:0]  wb_fflags, wb_vreg, fflags_acc;

    always #5 clk = ~clk;

    aq_vfmau_wb_buf #(
        .DEPTH    (c_DEPTH),
        .TAG_W    (c_TB_TAG_W),
        .STALL_TH (c_STALL_TH)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .ex3_vld        (ex3_vld),
        .ex4_vld        (ex4_vld),
        .ex5_vld        (ex5_vld),
        .ex3_result     (ex3_result),
        .ex4_result     (ex4_result),
        .ex5_result     (ex5_result),
        .ex3_fflags     (ex3_fflags),
        .ex4_fflags     (ex4_fflags),
        .ex5_fflags     (ex5_fflags),
        .ex3_vreg       (ex3_vreg),
        .ex4_vreg       (ex4_vreg),
        .ex5_vreg       (ex5_vreg),
        .rtu_vpu_flush  (flush),
        .vpu_wb_grant   (grant),
        .fflags_acc_clr (clr),
        .wb_vld         (wb_vld),
        .wb_data        (wb_data),
        .wb_fflags      (wb_fflags),
        .wb_vreg        (wb_vreg),
        .wb_stall       (wb_stall),
        .fflags_acc     (fflags_acc),
        .wb_ovf_err     (wb_ovf_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] data_of(input logic [4:0] t);
        return 64'h3FF0_0000_0000_0000 ^ ({59'd0, t ^ 5'd7} << 20);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; flush = 1'b0; grant = 1'b0; clr = 1'b0;
        ex3_vld = 1'b0; ex4_vld = 1'b0; ex5_vld = 1'b0;
        ex3_vreg = '0; ex4_vreg = '0; ex5_vreg = '0;
        ex3_fflags = '0; ex4_fflags = '0; ex5_fflags = '0;
        ex3_result = '0; ex4_result = '0; ex5_result = '0;
    endtask

    task automatic push3(input logic [4:0] tag, input logic [4:0] ff);
        ex3_vld = 1'b1; ex3_vreg = tag; ex3_fflags = ff; ex3_result = data_of(tag);
    endtask

    // Directed vectors: inputs applied for one edge, expected outputs after it.
    typedef struct {
        logic       rst_n, flush, grant, clr;
        logic [2:0] vld;            // {ex3, ex4, ex5}
        logic [4:0] t5, t4, t3, f5, f4, f3;
        logic       e_vld, e_stall, e_ovf;
        logic [4:0] e_vreg, e_ff, e_acc;
    } vec_t;

    vec_t tbl [21];

    // Reference model: an ordered queue of outstanding results.
    wb_entry_t  mq [$];
    logic [4:0] m_acc;
    logic       m_ovf;

    function automatic logic m_stall();
        return (c_DEPTH - mq.size()) < c_STALL_TH;
    endfunction

    task automatic model_step();
        int         n;
        logic       pop;
        logic [4:0] hf;
        wb_entry_t  e;
        if (!rst_n) begin
            mq.delete(); m_acc = '0; m_ovf = 1'b0;
        end else if (flush) begin
            mq.delete();
        end else begin
            n   = mq.size();
            pop = (n != 0) && grant;
            hf  = pop ? mq[0].fflags : 5'd0;
            if (ex5_vld) begin
                if (n < c_DEPTH) begin e = '{ex5_result, ex5_fflags, ex5_vreg}; mq.push_back(e); n++; end
                else m_ovf = 1'b1;
            end
            if (ex4_vld) begin
                if (n < c_DEPTH) begin e = '{ex4_result, ex4_fflags, ex4_vreg}; mq.push_back(e); n++; end
                else m_ovf = 1'b1;
            end
            if (ex3_vld) begin
                if (n < c_DEPTH) begin e = '{ex3_result, ex3_fflags, ex3_vreg}; mq.push_back(e); n++; end
                else m_ovf = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            m_acc = (clr ? 5'd0 : m_acc) | hf;
        end
    endtask

    task automatic model_check(input int cyc);
        check($sformatf("rnd%0d_vld", cyc), 64'(wb_vld), 64'(mq.size() != 0));
        check($sformatf("rnd%0d_stall", cyc), 64'(wb_stall), 64'(m_stall()));
        check($sformatf("rnd%0d_acc", cyc), 64'(fflags_acc), 64'(m_acc));
        check($sformatf("rnd%0d_ovf", cyc), 64'(wb_ovf_err), 64'(m_ovf));
        if (mq.size() != 0) begin
            check($sformatf("rnd%0d_vreg", cyc), 64'(wb_vreg), 64'(mq[0].vreg));
            check($sformatf("rnd%0d_data", cyc), wb_data, mq[0].data);
            check($sformatf("rnd%0d_ff", cyc), 64'(wb_fflags), 64'(mq[0].fflags));
        end
    endtask

    initial begin
        //         rst fl gr cl vld     t5 t4 t3 f5  f4 f3  ev es eo vreg ff  acc
        tbl[0]  = '{0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0,  0};
        tbl[1]  = '{0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0,  0};
        tbl[2]  = '{1, 0, 1, 0, 3'b100, 0, 0, 7, 0,  0, 1,  1, 0, 0, 7,   1,  0};
        tbl[3]  = '{1, 0, 1, 0, 3'b000, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0,  1};
        tbl[4]  = '{1, 0, 1, 0, 3'b111, 1, 2, 3, 0,  0, 0,  1, 1, 0, 1,   0,  1};
        tbl[5]  = '{1, 0, 1, 0, 3'b000, 0, 0, 0, 0,  0, 0,  1, 1, 0, 2,   0,  1};
        tbl[6]  = '{1, 0, 1, 0, 3'b000, 0, 0, 0, 0,  0, 0,  1, 0, 0, 3,   0,  1};
        tbl[7]  = '{1, 0, 1, 0, 3'b000, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0,  1};
        tbl[8]  = '{1, 0, 0, 0, 3'b111, 4, 5, 6, 16, 2, 8,  1, 1, 0, 4,   16, 1};
        tbl[9]  = '{1, 1, 1, 0, 3'b100, 0, 0, 9, 0,  0, 4,  0, 0, 0, 0,   0,  1};
        tbl[10] = '{1, 0, 0, 1, 3'b100, 0, 0, 10, 0, 0, 16, 1, 0, 0, 10,  16, 0};
        tbl[11] = '{1, 0, 1, 0, 3'b000, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0,  16};
        tbl[12] = '{1, 0, 0, 0, 3'b100, 0, 0, 11, 0, 0, 4,  1, 0, 0, 11,  4,  16};
        tbl[13] = '{1, 0, 1, 1, 3'b000, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0,  4};
        tbl[14] = '{1, 0, 0, 0, 3'b010, 0, 12, 0, 0, 3, 0,  1, 0, 0, 12,  3,  4};
        tbl[15] = '{1, 0, 1, 0, 3'b101, 13, 0, 14, 0, 0, 0, 1, 1, 0, 13,  0,  7};
        tbl[16] = '{1, 0, 1, 0, 3'b000, 0, 0, 0, 0,  0, 0,  1, 0, 0, 14,  0,  7};
        tbl[17] = '{1, 0, 1, 1, 3'b000, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0,  0};
        tbl[18] = '{1, 0, 0, 0, 3'b001, 15, 0, 0, 31, 0, 0, 1, 0, 0, 15,  31, 0};
        tbl[19] = '{0, 0, 1, 0, 3'b100, 0, 0, 16, 0, 0, 0,  0, 0, 0, 0,   0,  0};
        tbl[20] = '{1, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0,  0};

        idle_inputs();
        rst_n = 1'b0;

        for (int r = 0; r < 21; r++) begin
            rst_n = tbl[r].rst_n; flush = tbl[r].flush; grant = tbl[r].grant; clr = tbl[r].clr;
            ex3_vld = tbl[r].vld[2]; ex4_vld = tbl[r].vld[1]; ex5_vld = tbl[r].vld[0];
            ex5_vreg = tbl[r].t5; ex4_vreg = tbl[r].t4; ex3_vreg = tbl[r].t3;
            ex5_fflags = tbl[r].f5; ex4_fflags = tbl[r].f4; ex3_fflags = tbl[r].f3;
            ex5_result = data_of(tbl[r].t5); ex4_result = data_of(tbl[r].t4);
            ex3_result = data_of(tbl[r].t3);
            step();
            check($sformatf("tbl%0d_vld", r), 64'(wb_vld), 64'(tbl[r].e_vld));
            check($sformatf("tbl%0d_stall", r), 64'(wb_stall), 64'(tbl[r].e_stall));
            check($sformatf("tbl%0d_ovf", r), 64'(wb_ovf_err), 64'(tbl[r].e_ovf));
            check($sformatf("tbl%0d_acc", r), 64'(fflags_acc), 64'(tbl[r].e_acc));
            if (tbl[r].e_vld) begin
                check($sformatf("tbl%0d_vreg", r), 64'(wb_vreg), 64'(tbl[r].e_vreg));
                check($sformatf("tbl%0d_data", r), wb_data, data_of(tbl[r].e_vreg));
                check($sformatf("tbl%0d_ff", r), 64'(wb_fflags), 64'(tbl[r].e_ff));
            end
            if (r == 0) begin
                check("reset_data", wb_data, 64'd0);
                check("reset_ff", 64'(wb_fflags), 64'd0);
                check("reset_vreg", 64'(wb_vreg), 64'd0);
            end
        end

        // Back-pressure: fill one per cycle, hold, then force an overflow.
        idle_inputs();
        for (int j = 0; j < 4; j++) begin
            idle_inputs();
            push3(5'(20 + j), 5'(1 << c_FFLAG_NX));
            step();
            check($sformatf("bp_fill%0d_stall", j), 64'(wb_stall), 64'(j >= 1));
            check($sformatf("bp_fill%0d_vreg", j), 64'(wb_vreg), 64'd20);
        end
        idle_inputs();
        for (int j = 0; j < 5; j++) begin
            step();
            check($sformatf("bp_hold%0d_data", j), wb_data, data_of(5'd20));
            check($sformatf("bp_hold%0d_stall", j), 64'(wb_stall), 64'd1);
        end
        check("bp_ovf_before", 64'(wb_ovf_err), 64'd0);
        push3(5'd24, 5'd0);
        step();
        check("bp_ovf_after", 64'(wb_ovf_err), 64'd1);
        idle_inputs();
        for (int j = 0; j < 4; j++) begin
            check($sformatf("bp_drain%0d_vreg", j), 64'(wb_vreg), 64'(20 + j));
            grant = 1'b1;
            step();
        end
        check("bp_empty_vld", 64'(wb_vld), 64'd0);
        check("bp_ovf_sticky", 64'(wb_ovf_err), 64'd1);

        // Wrap-around: alternate push and pop for ten results.
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            push3(5'(i + 1), 5'd0);
            step();
            check($sformatf("wrap%0d_vreg", i), 64'(wb_vreg), 64'(i + 1));
            idle_inputs();
            grant = 1'b1;
            step();
            check($sformatf("wrap%0d_empty", i), 64'(wb_vld), 64'd0);
        end

        // Randomized run against the queue model.
        idle_inputs();
        rst_n = 1'b0;
        model_step();
        step();
        for (int c = 0; c < 600; c++) begin
            logic honor;
            logic st;
            st    = m_stall();
            honor = ($urandom_range(0, 19) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 29) == 0);
            grant = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 9) == 0);
            ex3_vld = 1'($urandom_range(0, 1)) & ~(honor & st);
            ex4_vld = 1'($urandom_range(0, 1)) & ~(honor & st);
            ex5_vld = 1'($urandom_range(0, 1)) & ~(honor & st);
            ex3_vreg = 5'($urandom); ex4_vreg = 5'($urandom); ex5_vreg = 5'($urandom);
            ex3_fflags = 5'($urandom); ex4_fflags = 5'($urandom); ex5_fflags = 5'($urandom);
            ex3_result = {$urandom, $urandom};
            ex4_result = {$urandom, $urandom};
            ex5_result = {$urandom, $urandom};
            model_step();
            step();
            model_check(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
